// File: rtl/riscv_id_if.sv
// IF->ID input and ID/EX register output bundle of the RV32I decode stage.
// slave = the decode stage itself, master = whoever drives fetch results and consumes ID/EX.
interface riscv_id_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            flush;
  logic            bubble;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [31:0]     id_imm;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;
  logic            id_jump;
  logic            id_alu_imm;
  logic            id_illegal;

  modport slave (
    input  if_pc, if_instr, flush,
    output bubble, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3,
           id_funct7, id_imm, id_reg_write, id_mem_read, id_mem_write, id_branch,
           id_jump, id_alu_imm, id_illegal
  );

  modport master (
    output if_pc, if_instr, flush,
    input  bubble, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3,
           id_funct7, id_imm, id_reg_write, id_mem_read, id_mem_write, id_branch,
           id_jump, id_alu_imm, id_illegal
  );
endinterface

// File: rtl/riscv_id.sv
// RV32I decode stage: field/immediate/control decode into an ID/EX register,
// load-use stall generation toward IF, and flush squashing from EX.
module riscv_id #(
  parameter int XLEN          = 32,
  parameter bit HAZARD_DETECT = 1'b1
) (
  input logic        clk,
  input logic        rst,
  riscv_id_if.slave  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_imm;
    logic            illegal;
  } idex_t;

  idex_t       dec, q;
  logic        use_rs1, use_rs2, load_use;
  logic [31:0] ins, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins   = bus.if_instr;
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Every legal opcode ends in 2'b11, so the case default also covers instr[1:0] != 2'b11.
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.pc     = bus.if_pc;
    dec.opcode = ins[6:0];
    dec.rd     = ins[11:7];
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.funct3 = ins[14:12];
    dec.funct7 = ins[31:25];
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    case (ins[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.imm = imm_j;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_i;
        use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1; dec.imm = imm_b;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_i;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_s;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_OPIMM: begin
        dec.reg_write = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_i;
        use_rs1 = 1'b1;
      end
      OP_OP: begin
        dec.reg_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_MISC:   dec.imm = 32'h0;
      OP_SYSTEM: dec.imm = imm_i;
      default:   dec.illegal = 1'b1;
    endcase
  end

  // Stall only against a load already sitting in ID/EX; the inserted NOP clears the condition.
  generate
    if (HAZARD_DETECT) begin : g_hz
      assign load_use = rst && !bus.flush && q.valid && q.mem_read && (q.rd != 5'd0) &&
                        ((use_rs1 && dec.rs1 == q.rd) || (use_rs2 && dec.rs2 == q.rd));
    end else begin : g_no_hz
      assign load_use = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)                        q <= '0;
    else if (bus.flush || load_use) q <= '0;
    else                             q <= dec;
  end

  assign bus.bubble       = load_use;
  assign bus.id_valid     = q.valid;
  assign bus.id_pc        = q.pc;
  assign bus.id_opcode    = q.opcode;
  assign bus.id_rd        = q.rd;
  assign bus.id_rs1       = q.rs1;
  assign bus.id_rs2       = q.rs2;
  assign bus.id_funct3    = q.funct3;
  assign bus.id_funct7    = q.funct7;
  assign bus.id_imm       = q.imm;
  assign bus.id_reg_write = q.reg_write;
  assign bus.id_mem_read  = q.mem_read;
  assign bus.id_mem_write = q.mem_write;
  assign bus.id_branch    = q.branch;
  assign bus.id_jump      = q.jump;
  assign bus.id_alu_imm   = q.alu_imm;
  assign bus.id_illegal   = q.illegal;

endmodule

// File: tb/tb_riscv_id.sv
// Decode-stage bench: directed scenarios plus random instruction streams, with the bench
// acting as IF (holding PC/instr on bubble) and a table-driven model predicting ID/EX.
module tb_riscv_id;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_id_if #(.XLEN(32)) bus();
  riscv_id #(.XLEN(32), .HAZARD_DETECT(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rw, mr, mw, br, jp, ai, ill;
  } st_t;

  st_t m;
  int  checks = 0;
  int  errors = 0;
  bit  last_bubble;

  function automatic bit uses1(logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit uses2(logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic st_t model_decode(logic [31:0] ins, logic [31:0] pc);
    st_t r; int imm; byte f; logic [5:0] c; bit ok;
    r = '0; r.valid = 1; r.pc = pc; r.opcode = ins[6:0]; r.rd = ins[11:7];
    r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.funct3 = ins[14:12]; r.funct7 = ins[31:25];
    ok = 1; f = "N"; c = '0;
    case (ins[6:0])  // c = {reg_write, mem_read, mem_write, branch, jump, alu_imm}
      7'h37, 7'h17: begin f = "U"; c = 6'b100001; end
      7'h6F:        begin f = "J"; c = 6'b100010; end
      7'h67:        begin f = "I"; c = 6'b100011; end
      7'h63:        begin f = "B"; c = 6'b000100; end
      7'h03:        begin f = "I"; c = 6'b110001; end
      7'h23:        begin f = "S"; c = 6'b001001; end
      7'h13:        begin f = "I"; c = 6'b100001; end
      7'h33:        begin f = "R"; c = 6'b100000; end
      7'h0F:        begin f = "N"; c = 6'b000000; end
      7'h73:        begin f = "I"; c = 6'b000000; end
      default: ok = 0;
    endcase
    if (ins[1:0] != 2'b11) ok = 0;
    if (!ok) begin r.ill = 1; return r; end
    case (f)
      "I": imm = int'($signed(ins) >>> 20);
      "S": imm = (int'($signed(ins)) >>> 25) * 32 + int'(ins[11:7]);
      "B": imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      "U": imm = int'(ins & 32'hFFFFF000);
      "J": imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: imm = 0;
    endcase
    r.imm = imm;
    {r.rw, r.mr, r.mw, r.br, r.jp, r.ai} = c;
    return r;
  endfunction

  function automatic bit model_bubble(logic [31:0] ins, bit fl, bit rs);
    if (!rs || fl || !m.valid || !m.mr || m.rd == 0) return 0;
    return (uses1(ins[6:0]) && ins[19:15] == m.rd) || (uses2(ins[6:0]) && ins[24:20] == m.rd);
  endfunction

  function automatic st_t dut_st();
    st_t r;
    r.valid = bus.id_valid; r.pc = bus.id_pc; r.opcode = bus.id_opcode; r.rd = bus.id_rd;
    r.rs1 = bus.id_rs1; r.rs2 = bus.id_rs2; r.funct3 = bus.id_funct3; r.funct7 = bus.id_funct7;
    r.imm = bus.id_imm; r.rw = bus.id_reg_write; r.mr = bus.id_mem_read; r.mw = bus.id_mem_write;
    r.br = bus.id_branch; r.jp = bus.id_jump; r.ai = bus.id_alu_imm; r.ill = bus.id_illegal;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One clock: drive inputs, check bubble, advance model, check registered outputs.
  task automatic cyc(logic [31:0] ins, logic [31:0] pc, bit fl, bit rs);
    st_t nx, d, e;
    bus.if_instr = ins; bus.if_pc = pc; bus.flush = fl; rst = rs;
    #1;
    last_bubble = model_bubble(ins, fl, rs);
    chk("bubble", {31'b0, bus.bubble}, {31'b0, last_bubble});
    if (!rs || fl || last_bubble) nx = '0;
    else nx = model_decode(ins, pc);
    @(posedge clk); #1;
    m = nx;
    d = dut_st(); e = m;
    if (e.ill) begin d.imm = '0; e.imm = '0; end
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL idex: got %h expected %h", d, e);
    end
  endtask

  logic [31:0] pc, ins;
  bit fl, rs;

  initial begin
    m = '0; rst = 0; bus.flush = 0; bus.if_pc = 0; bus.if_instr = 0;
    // Reset, then first decode
    cyc(32'h00500093, 32'd4, 0, 0);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_rd", {27'b0, bus.id_rd}, 32'd0);
    cyc(32'h00500093, 32'd4, 0, 1);
    chk("addi_pc", bus.id_pc, 32'd4);
    chk("addi_rd", {27'b0, bus.id_rd}, 32'd1);
    chk("addi_imm", bus.id_imm, 32'd5);
    chk("addi_ctl", {29'b0, bus.id_reg_write, bus.id_alu_imm, bus.id_mem_read}, 32'b110);
    // Load-use stall
    cyc(32'h0000A103, 32'd8, 0, 1);
    cyc(32'h001101B3, 32'd12, 0, 1);
    chk("lu_bubble", {31'b0, last_bubble}, 32'd1);
    chk("lu_nop", {31'b0, bus.id_valid}, 32'd0);
    cyc(32'h001101B3, 32'd12, 0, 1);
    chk("lu_regs", {17'b0, bus.id_rd, bus.id_rs1, bus.id_rs2}, {17'b0, 5'd3, 5'd2, 5'd1});
    // Independent add: no stall
    cyc(32'h0000A103, 32'd16, 0, 1);
    cyc(32'h005201B3, 32'd20, 0, 1);
    chk("nohz_valid", {31'b0, bus.id_valid}, 32'd1);
    // Immediates
    cyc(32'hFE000CE3, 32'd24, 0, 1);
    chk("beq_imm", bus.id_imm, 32'hFFFFFFF8);
    chk("beq_ctl", {30'b0, bus.id_branch, bus.id_reg_write}, 32'b10);
    cyc(32'h123452B7, 32'd28, 0, 1);
    chk("lui_imm", bus.id_imm, 32'h12345000);
    cyc(32'hFE20AE23, 32'd32, 0, 1);
    chk("sw_imm", bus.id_imm, 32'hFFFFFFFC);
    chk("sw_mw", {31'b0, bus.id_mem_write}, 32'd1);
    // Illegal encodings
    cyc(32'hFFFFFFFF, 32'd36, 0, 1);
    chk("ill_ff", {25'b0, bus.id_valid, bus.id_illegal, bus.id_reg_write, bus.id_mem_read,
                   bus.id_mem_write, bus.id_branch, bus.id_jump}, 32'b1100000);
    cyc(32'h00000000, 32'd40, 0, 1);
    chk("ill_00", {25'b0, bus.id_valid, bus.id_illegal, bus.id_reg_write, bus.id_mem_read,
                   bus.id_mem_write, bus.id_branch, bus.id_jump}, 32'b1100000);
    // Flush beats hazard; reset mid-hazard
    cyc(32'h0000A103, 32'd44, 0, 1);
    cyc(32'h001101B3, 32'd48, 1, 1);
    chk("fl_valid", {31'b0, bus.id_valid}, 32'd0);
    cyc(32'h0000A103, 32'd52, 0, 1);
    cyc(32'h001101B3, 32'd56, 0, 0);
    chk("rst_hz_valid", {31'b0, bus.id_valid}, 32'd0);

    // Random streams; bench behaves as IF and re-presents the instruction on a bubble
    pc = 32'h100; ins = 32'h13;
    for (int i = 0; i < 3000; i++) begin
      if (!last_bubble) begin
        logic [6:0] ops [12];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        ins = $urandom;
        if ($urandom_range(0, 15) != 0) begin
          ins[6:0]   = ops[$urandom_range(0, 11)];
          ins[11:7]  = 5'($urandom_range(0, 3));
          ins[19:15] = 5'($urandom_range(0, 3));
          ins[24:20] = 5'($urandom_range(0, 3));
        end
        pc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFFFFFC) : pc + 4;
      end
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 49) != 0);
      cyc(ins, pc, fl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_id.md
Name: riscv_id

Overview:
- RV32I instruction decode stage, directly downstream of riscv_if.
- Takes the PC from riscv_if and the instruction word fetched at that PC; decodes fields, immediate and control signals into a registered ID/EX pipeline register.
- Detects load-use hazards and drives riscv_if's bubble input so IF holds its PC.
- Accepts a flush from EX (taken branch/jump) to squash the instruction being decoded.

Parameters:
XLEN, 32, datapath/PC width; only 32 supported.
HAZARD_DETECT, 1, 1 = load-use detection enabled; 0 = bubble tied low.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low.
if_pc  in  32  PC from riscv_if.
if_instr  in  32  instruction word at if_pc, valid same cycle.
flush  in  1  squash the instruction currently at the input.
bubble  out  1  combinational; to riscv_if bubble input.
id_valid  out  1  ID/EX register holds a real instruction.
id_pc  out  32  PC of the decoded instruction.
id_opcode  out  7  instr[6:0].
id_rd, id_rs1, id_rs2  out  5 each  register fields.
id_funct3  out  3  instr[14:12].
id_funct7  out  7  instr[31:25].
id_imm  out  32  sign-extended immediate.
id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_imm  out  1 each  control.
id_illegal  out  1  unsupported encoding.

Behaviour:
- All id_* outputs are registered and update on the rising clk edge; latency 1 cycle from if_instr to id_*.
- Reset: when rst is 0 at an edge, all id_* outputs clear to 0. bubble is forced to 0 combinationally while rst is 0. Reset mid-hazard drops the stall on the same edge.
- Immediate formats:
  - I (LOAD, OP-IMM, JALR, SYSTEM): instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - OP: 0. All sign-extended to 32 bits.
- Control by opcode:
  - LUI, AUIPC: reg_write, alu_imm.
  - JAL: reg_write, jump.
  - JALR: reg_write, jump, alu_imm.
  - BRANCH: branch.
  - LOAD: reg_write, mem_read, alu_imm.
  - STORE: mem_write, alu_imm.
  - OP-IMM: reg_write, alu_imm.
  - OP: reg_write.
  - MISC-MEM and SYSTEM: valid, no controls set.
- Illegal: any other opcode, or instr[1:0] != 2'b11. Result: id_valid=1, id_illegal=1, all other controls 0. Raw fields are still output.
- Source use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
- Load-use hazard: bubble=1 when all of the following hold:
  - HAZARD_DETECT=1
  - id_valid=1 and id_mem_read=1 and id_rd != 0
  - the input instruction uses rs1 or rs2 equal to id_rd
  - flush=0
- On a hazard edge: the ID/EX register loads a NOP (id_valid=0, all controls 0, other fields 0). IF holds its PC, so the same instruction reappears next cycle. Because the NOP has id_mem_read=0, the stall lasts exactly 1 cycle.
- Flush: the ID/EX register loads a NOP and bubble=0. Flush has priority over the hazard.
- Normal edge (no flush, no hazard): id_valid=1 and decoded fields are loaded.
- A write to x0 is still decoded with reg_write=1. x0 never triggers a hazard.

Test Plan:
- Reset: rst=0 for 1 edge, if_instr=0x00500093 -> all id_* = 0, bubble=0. Release: next edge id_valid=1.
- addi x1,x0,5 (0x00500093), if_pc=4 -> after 1 edge: id_pc=4, id_rd=1, id_rs1=0, id_imm=5, id_reg_write=1, id_alu_imm=1, id_mem_read=0.
- Load-use, with bubble wired to riscv_if: lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3).
  - Cycle after lw is latched: bubble=1, IF PC held.
  - Next edge: id_valid=0.
  - Following edge: add decoded, id_rd=3, id_rs1=2, id_rs2=1, bubble=0.
  - Repeat with add x3,x4,x5 -> bubble stays 0.
- Immediates:
  - beq x0,x0,-8 (0xFE000CE3) -> id_imm=0xFFFFFFF8, id_branch=1, id_reg_write=0.
  - lui x5,0x12345 (0x123452B7) -> id_imm=0x12345000, id_rd=5.
  - sw x2,-4(x1) (0xFE20AE23) -> id_imm=0xFFFFFFFC, id_mem_write=1.
- Illegal: 0xFFFFFFFF and 0x00000000 -> id_valid=1, id_illegal=1, all write/mem/branch/jump controls 0.
- Flush priority: lw x2 latched, then add x3,x2,x1 at input with flush=1 -> bubble=0; next edge id_valid=0. Reset asserted during a hazard cycle -> bubble=0 immediately, outputs 0 next edge.
